serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell and a registered carry. It consumes one operand bit pair per clock, LSB first, and after WIDTH cycles presents the registered sum and carry-out behind a start/busy/done handshake. It sits between the lab's switch/register front end, which supplies the operands and strobes `start`, and the display/LED back end, which reads the result. It is the area-minimal companion to the ripple-carry adders in the same lab.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_fa_cell.sv | 15 +
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit counter width; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned w);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(w)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder used as the serial adder's datapath cell.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_s, cell_co;
  logic [WIDTH-1:0] shift_w;

  serial_fa_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (c_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // The result register holds WIDTH-1 bits; the final sum bit joins it
  // directly on the way into sum.
  always_comb shift_w = {cell_s, res_q};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = ci;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d  = shift_w[WIDTH-1:1];
        c_d    = cell_co;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = shift_w;
          co_d    = cell_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ cell_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ci    = 1'b0;
  logic         busy, done, co;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [W-1:0] hold_sum = '0;
  logic         hold_co  = 1'b0;
  logic         hold_ovf = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic, unsigned for sum/co, signed for ovf.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    longint total, sx, sy, st;
    logic   v;
    logic   cout;
    total = longint'(x) + longint'(y) + longint'(c);
    sx = (longint'(x) >= (64'sd1 <<< (W - 1))) ? longint'(x) - (64'sd1 <<< W) : longint'(x);
    sy = (longint'(y) >= (64'sd1 <<< (W - 1))) ? longint'(y) - (64'sd1 <<< W) : longint'(y);
    st = sx + sy + longint'(c);
    v = (st > (64'sd1 <<< (W - 1)) - 1) || (st < -(64'sd1 <<< (W - 1)));
    cout = (total >= (64'sd1 <<< W));
    return {v, cout, W'(total)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_running(input string name);
    check({name, ".busy"}, 32'(busy), 32'd1);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".sum_hold"}, 32'(sum), 32'(hold_sum));
    check({name, ".co_hold"}, 32'(co), 32'(hold_co));
  endtask

  task automatic check_done(input string name, input logic [W-1:0] es, input logic eco,
                            input logic eov);
    check({name, ".done"}, 32'(done), 32'd1);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".sum"}, 32'(sum), 32'(es));
    check({name, ".co"}, 32'(co), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
    check({name, ".ovf"}, 32'(ovf), 32'(eov));
`endif
    hold_sum = es;
    hold_co  = eco;
    hold_ovf = eov;
  endtask

  task automatic check_quiet(input string name);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
  endtask

  // One-cycle start, then WIDTH busy cycles, then a single done cycle.
  task automatic run_add(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tci, input bit garble, input logic [W-1:0] es,
                         input logic eco, input logic eov);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; ci = tci;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        if (garble) begin
          a  = W'($urandom);
          b  = W'($urandom);
          ci = 1'($urandom);
        end
      end
      check_running(name);
    end
    @(negedge clk);
    check_done(name, es, eco, eov);
    @(negedge clk);
    check_quiet({name, ".after"});
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic         bb_c[3];

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.co", 32'(co), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset.ovf", 32'(ovf), 32'd0);
`endif

    // Reset wins over a simultaneous start
    start = 1'b1; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    check_quiet("rst_vs_start");
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check_quiet("rst_vs_start.idle");

    // Directed table
    for (int i = 0; i < 7; i++)
      run_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0,
              vecs[i].s, vecs[i].co, vecs[i].ovf);

    // Start during RUN (sampled at E3, operands zeroed) is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h3C; b = 8'h05; ci = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 2) begin start = 1'b1; a = '0; b = '0; end
      if (k == 3) start = 1'b0;
      check_running("ign_start");
    end
    @(negedge clk);
    check_done("ign_start", 8'h41, 1'b0, 1'b0);

    // Reset asserted at E4 of a run
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h33; ci = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("mid_rst");
    check("mid_rst.sum", 32'(sum), 32'd0);
    check("mid_rst.co", 32'(co), 32'd0);
    hold_sum = '0; hold_co = 1'b0; hold_ovf = 1'b0;
    for (int k = 0; k < int'(W) + 2; k++) begin
      @(negedge clk);
      check_quiet("mid_rst.no_done");
    end
    run_add("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    // Back-to-back with start held high
    for (int r = 0; r < 3; r++) begin
      bb_a[r] = W'($urandom);
      bb_b[r] = W'($urandom);
      bb_c[r] = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; a = bb_a[0]; b = bb_b[0]; ci = bb_c[0];
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'(W); k++) begin
        @(negedge clk);
        check_running($sformatf("b2b%0d", r));
      end
      @(negedge clk);
      m = model(bb_a[r], bb_b[r], bb_c[r]);
      check_done($sformatf("b2b%0d", r), m[W-1:0], m[W], m[W+1]);
      if (r < 2) begin
        a = bb_a[r+1]; b = bb_b[r+1]; ci = bb_c[r+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_quiet("b2b.end");

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 8'h7F; rb = 8'h7F; rc = 1'b1; end
      m = model(ra, rb, rc);
      run_add($sformatf("rnd%0d", i), ra, rb, rc, 1'b1, m[W-1:0], m[W], m[W+1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
